// File: rtl/metaball_pkg.sv
// rtl/metaball_pkg.sv - shared fixed-point constants, types and scheduler state encoding
package metaball_pkg;

   localparam int          Q_FRAC = 15;
   localparam logic [31:0] ONE    = 32'h0000_8000;

   typedef logic [31:0] fix_t;

   typedef enum logic [2:0] {
      IDLE,
      MOVE,
      STROBE,
      ARM,
      WAIT,
      SUM,
      WRITE
   } sched_state_t;

endpackage

// File: rtl/metaball_sched_sat_sum.sv
// rtl/metaball_sched_sat_sum.sv - combinational N-input saturating adder of Q17.15 contributions
module sat_sum
   import metaball_pkg::*;
#(
   parameter int N_BALLS = 4
) (
   input  logic [N_BALLS*32-1:0] terms,
   output logic [31:0]           sum
);

   // Wide enough that the sum of N full-scale terms never wraps.
   localparam int ACC_W = 32 + $clog2(N_BALLS);

   logic [ACC_W-1:0] acc;
   fix_t             term;

   // Accumulate every term, then clamp anything above 32 bits to all-ones.
   always_comb begin
      acc  = '0;
      term = '0;
      for (int i = 0; i < N_BALLS; i++) begin
         term = terms[i*32 +: 32];
         acc  = acc + ACC_W'(term);
      end
      sum = (acc > ACC_W'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : acc[31:0];
   end

endmodule

// File: rtl/metaball_sched.sv
// rtl/metaball_sched.sv - frame scheduler for the metaball datapath; optional watchdog via METABALL_SCHED_WATCHDOG_EN
module metaball_sched
   import metaball_pkg::*;
#(
   parameter int          N_BALLS = 4,
   parameter int          DISP_W  = 32,
   parameter int          DISP_H  = 64,
   parameter logic [31:0] THRESH  = ONE,
   parameter int          TIMEOUT = 255
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             frame_tick,
   output logic                             mov_en,
   output logic                             px_stb,
   output logic [31:0]                      p_x,
   output logic [31:0]                      p_y,
   input  logic [N_BALLS-1:0]               ball_vld,
   input  logic [N_BALLS*32-1:0]            ball_out,
   output logic                             fb_we,
   input  logic                             fb_rdy,
   output logic [$clog2(DISP_W*DISP_H)-1:0] fb_addr,
   output logic [31:0]                      fb_data,
   output logic                             fb_on,
   output logic                             busy,
   output logic                             frame_done,
   output logic                             overrun
`ifdef METABALL_SCHED_WATCHDOG_EN
   ,
   output logic                             wd_err
`endif
);

   localparam int AW = $clog2(DISP_W*DISP_H);
   localparam int CW = $clog2(DISP_W);
   localparam int RW = $clog2(DISP_H);

   localparam logic [2:0] S_IDLE   = IDLE;
   localparam logic [2:0] S_MOVE   = MOVE;
   localparam logic [2:0] S_STROBE = STROBE;
   localparam logic [2:0] S_ARM    = ARM;
   localparam logic [2:0] S_WAIT   = WAIT;
   localparam logic [2:0] S_SUM    = SUM;
   localparam logic [2:0] S_WRITE  = WRITE;

   logic [2:0]    state;
   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic          pending;
   logic          last_col;
   logic          last_row;
   fix_t          sum;

`ifdef METABALL_SCHED_WATCHDOG_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] wd_cnt;
   logic          wd_force;
`endif

   sat_sum #(
      .N_BALLS(N_BALLS)
   ) u_sat_sum (
      .terms(ball_out),
      .sum  (sum)
   );

   assign last_col = (col == CW'(DISP_W - 1));
   assign last_row = (row == RW'(DISP_H - 1));

   assign mov_en  = (state == S_MOVE);
   assign px_stb  = (state == S_STROBE);
   assign fb_we   = (state == S_WRITE);
   assign busy    = (state != S_IDLE);
   assign p_x     = 32'(col) << Q_FRAC;
   assign p_y     = 32'(row) << Q_FRAC;
   assign fb_addr = AW'(row) * AW'(DISP_W) + AW'(col);

   // Tick bookkeeping: a busy-time tick is remembered once, a second one is counted as overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         overrun <= 1'b0;
      end else if (state == S_IDLE) begin
         pending <= 1'b0;
      end else if (frame_tick) begin
         if (!pending) pending <= 1'b1;
         else          overrun <= 1'b1;
      end
   end

   // Per-pixel sequencer: strobe, skip the stale-valid cycle, wait for all balls, sum, write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         col        <= '0;
         row        <= '0;
         fb_data    <= '0;
         fb_on      <= 1'b0;
         frame_done <= 1'b0;
`ifdef METABALL_SCHED_WATCHDOG_EN
         wd_cnt     <= '0;
         wd_force   <= 1'b0;
         wd_err     <= 1'b0;
`endif
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (frame_tick || pending) state <= S_MOVE;
            end
            S_MOVE: begin
               col   <= '0;
               row   <= '0;
               state <= S_STROBE;
            end
            S_STROBE: state <= S_ARM;
            S_ARM:    state <= S_WAIT;
            S_WAIT: begin
`ifdef METABALL_SCHED_WATCHDOG_EN
               if (&ball_vld) begin
                  wd_cnt <= '0;
                  state  <= S_SUM;
               end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                  wd_cnt   <= '0;
                  wd_force <= 1'b1;
                  wd_err   <= 1'b1;
                  state    <= S_SUM;
               end else begin
                  wd_cnt <= wd_cnt + TW'(1);
               end
`else
               if (&ball_vld) state <= S_SUM;
`endif
            end
            S_SUM: begin
`ifdef METABALL_SCHED_WATCHDOG_EN
               fb_data  <= wd_force ? 32'h0 : sum;
               fb_on    <= wd_force ? 1'b0 : (sum >= THRESH);
               wd_force <= 1'b0;
`else
               fb_data <= sum;
               fb_on   <= (sum >= THRESH);
`endif
               state <= S_WRITE;
            end
            S_WRITE: begin
               if (fb_rdy) begin
                  if (last_col && last_row) begin
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                  end else if (last_col) begin
                     col   <= '0;
                     row   <= row + RW'(1);
                     state <= S_STROBE;
                  end else begin
                     col   <= col + CW'(1);
                     state <= S_STROBE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/metaball_sched.md
Name: metaball_sched

Overview:
- Frame scheduler for the metaball render datapath.
- On each frame tick, pulses the move enable to all metaball instances, then walks every pixel in raster order: strobes the shared pixel coordinate, waits for every ball's divider to finish, sums the contributions with saturation, thresholds the sum, and writes the result to the framebuffer.
- Sits between the 60 Hz frame timer and the N metaball instances plus framebuffer.

Parameters:
- N_BALLS, 4, number of metaball instances driven in parallel.
- DISP_W, 32, display width in pixels.
- DISP_H, 64, display height in pixels.
- THRESH, 32'h0000_8000, Q17.15 on-threshold (1.0).
- TIMEOUT, 255, max WAIT cycles per pixel; used only with the watchdog feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle frame start strobe (60 Hz)
- mov_en  out  1  one-cycle move pulse to all metaballs
- px_stb  out  1  one-cycle pixel strobe to all metaballs
- p_x  out  32  pixel x in Q17.15 (col<<15)
- p_y  out  32  pixel y in Q17.15 (row<<15)
- ball_vld  in  N_BALLS  per-ball result valid
- ball_out  in  N_BALLS x 32  per-ball Q17.15 contribution
- fb_we  out  1  framebuffer write request
- fb_rdy  in  1  framebuffer accepts the write this cycle
- fb_addr  out  $clog2(DISP_W*DISP_H)  row*DISP_W+col
- fb_data  out  32  saturated sum
- fb_on  out  1  fb_data >= THRESH
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is written
- overrun  out  1  sticky: tick arrived while a tick was already pending

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; col/row/pending/overrun cleared. Reset mid-frame abandons the frame; no partial write completes.
- States:
  - IDLE: if frame_tick or pending, go to MOVE and clear pending.
  - MOVE: mov_en=1 for one cycle; col=row=0; go to STROBE.
  - STROBE: px_stb=1 for one cycle; p_x/p_y already hold the current col/row and stay stable until the next STROBE; go to ARM.
  - ARM: one dead cycle, because ball_vld may still be high from the previous pixel; go to WAIT.
  - WAIT: when &ball_vld=1, go to SUM. Partial vld is ignored.
  - SUM: register the saturating sum of all ball_out into fb_data; set fb_on; go to WRITE.
  - WRITE: hold fb_we, fb_addr, fb_data, fb_on until the cycle fb_rdy=1, then deassert fb_we. If col=DISP_W-1 and row=DISP_H-1, pulse frame_done and go to IDLE. Else if col=DISP_W-1, col=0 and row++, go to STROBE. Else col++, go to STROBE.
- Arithmetic:
  - Sum uses a 32+clog2(N) bit accumulator, clamped to 32'hFFFF_FFFF.
  - fb_on uses an unsigned compare against THRESH.
- Ticks:
  - frame_tick while busy: set pending if clear; if pending is already set, set overrun and drop the tick.
  - frame_tick in IDLE is consumed directly and never sets pending.
- Latency: minimum per pixel = D+4 cycles (D = divider latency); frame = 1 + W*H*(D+4) cycles with fb_rdy tied high.
- fb_rdy low stalls only in WRITE; no other state depends on it.

Optional Feature:
- Macro: METABALL_SCHED_WATCHDOG_EN.
- With the macro: a WAIT cycle counter runs. Reaching TIMEOUT forces SUM with fb_data=0, fb_on=0, and sets a sticky output wd_err (port present only under the macro).
- Without the macro: WAIT blocks indefinitely; no counter, no wd_err port.

Decomposition:
- Shared package metaball_pkg: Q_FRAC=15, ONE=32'h0000_8000, typedef fix_t (logic [31:0]), sched_state_t enum {IDLE, MOVE, STROBE, ARM, WAIT, SUM, WRITE}.
- One sub-module, sat_sum: combinational N-input saturating adder, parameterized on N_BALLS.

Test Plan:
- Reset: rst_n low during WAIT at pixel (5,3) -> all outputs 0 immediately; after release with no tick, state stays IDLE; next tick starts at pixel (0,0).
- Full frame, DISP_W=4, DISP_H=2, N=2 stub balls (vld after 3 cycles, out=32'h0000_4000 each), fb_rdy=1:
  - 8 writes, addresses 0..7, fb_data=32'h0000_8000, fb_on=1.
  - mov_en pulses once before the first px_stb.
  - frame_done occurs exactly once.
  - p_x on the 2nd pixel is 32'h0000_8000.
- Saturation/threshold: outs 32'hFFFF_0000 + 32'h0002_0000 -> fb_data=32'hFFFF_FFFF. Outs 32'h0000_7FFF + 0 -> fb_on=0.
- Stale vld: stub holds vld=1 through px_stb and drops it 1 cycle later -> no SUM before the new vld rises.
- Backpressure: fb_rdy low for 5 cycles in WRITE -> fb_we/addr/data stable for 6 cycles, exactly one write, and no new px_stb until after the write.
- Overrun: 3 ticks during a busy frame -> overrun=1. Next frame starts immediately from pending (mov_en the cycle after IDLE).
- With METABALL_SCHED_WATCHDOG_EN, TIMEOUT=10: one ball never asserts vld -> fb_data=0 written, wd_err=1, and the frame completes.
